// File: rtl/psx_dmac_pkg.sv
// Shared DMAC definitions: channel FSM encoding, BCR block-size field bounds,
// ordering-table terminator and fill-mode selector.
package psx_dmac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_REQ   = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } dmac_state_e;

    typedef enum logic {
        MODE_OT   = 1'b0,
        MODE_FILL = 1'b1
    } dmac_mode_e;

    localparam int          DMAC_BCR_BLK_SIZE_LSB = 0;
    localparam int          DMAC_BCR_BLK_SIZE_MSB = 15;
    localparam logic [31:0] DMAC_OT_END_DEFAULT   = 32'h00FF_FFFF;
    localparam logic [1:0]  DMAC_BUS_SIZE_WORD    = 2'd2;

    // OT entries point at the next-lower entry; only 24 address bits are kept.
    function automatic logic [31:0] ot_link_word(input logic [29:0] prev_word_addr);
        return {8'h00, prev_word_addr[21:0], 2'b00};
    endfunction

endpackage

// File: rtl/dmac_burst_len_calc.sv
// Beats in the next burst: limited by words remaining and by the distance to
// the next BURST_LEN-word aligned boundary.
module dmac_burst_len_calc #(
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16,
    localparam int OFS_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic [OFS_W-1:0] addr_lo,
    input  logic [CNT_W:0]   remaining,
    output logic [4:0]       len
);
    localparam int RW = CNT_W + 1;

    logic [5:0] room;

    always_comb begin
        room = 6'(BURST_LEN - (int'(addr_lo) % BURST_LEN));
        if (remaining < RW'(room))
            len = 5'(remaining);
        else
            len = 5'(room);
    end

endmodule

// File: rtl/dmac_ot_fill.sv
// DMAC channel-6 engine: writes a reverse-linked ordering table or a constant
// word over a RAM region in one ascending pass of aligned bursts.
module dmac_ot_fill
    import psx_dmac_pkg::*;
#(
    parameter int          BURST_LEN = 16,
    parameter int          CNT_W     = DMAC_BCR_BLK_SIZE_MSB - DMAC_BCR_BLK_SIZE_LSB + 1,
    parameter logic [31:0] OT_END    = DMAC_OT_END_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_ASYNC,
    input  logic        EN,
    input  logic [31:0] CFG_DMAC_MADR_IN,
    input  logic [31:0] CFG_DMAC_BCR_IN,
    input  logic        CFG_MODE_IN,
    input  logic [31:0] CFG_FILL_DATA_IN,
    input  logic        CFG_DMAC_CHCR_TR_IN,
    input  logic        CFG_ABORT_IN,
    output logic        CFG_DMAC_CHCR_TR_CLR_OUT,
    output logic        DONE_IRQ_OUT,
    output logic        BUSY_OUT,
    output logic [31:0] BUS_START_ADDR_OUT,
    output logic        BUS_READ_REQ_OUT,
    output logic        BUS_WRITE_REQ_OUT,
    input  logic        BUS_WRITE_ACK_IN,
    input  logic        BUS_LAST_ACK_IN,
    input  logic        BUS_READ_ACK_IN,
    input  logic [31:0] BUS_READ_DATA_IN,
    output logic [1:0]  BUS_SIZE_OUT,
    output logic [4:0]  BUS_LEN_OUT,
    output logic        BUS_BURST_ADDR_INC_OUT,
    output logic [31:0] BUS_WRITE_DATA_OUT
);
    localparam int RW    = CNT_W + 1;
    localparam int OFS_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    dmac_state_e state;
    dmac_mode_e  mode_q;
    logic [29:0] addr_q;
    logic [RW-1:0] rem_q;
    logic [31:0] fill_q;
    logic        abort_q;

    logic [RW-1:0] n_words;
    logic [29:0]   s_word;
    logic [29:0]   calc_addr;
    logic [RW-1:0] calc_rem;
    logic [4:0]    len_c;

    logic unused_inputs;
    assign unused_inputs = ^{BUS_READ_ACK_IN, BUS_READ_DATA_IN,
                             CFG_DMAC_BCR_IN[31:CNT_W], CFG_DMAC_MADR_IN[1:0]};

    assign BUS_READ_REQ_OUT       = 1'b0;
    assign BUS_SIZE_OUT           = DMAC_BUS_SIZE_WORD;
    assign BUS_BURST_ADDR_INC_OUT = 1'b1;

    // A zero count means a full 2^CNT_W words; the run ends at the head entry.
    assign n_words = (CFG_DMAC_BCR_IN[CNT_W-1:0] == '0) ? {1'b1, {CNT_W{1'b0}}}
                                                        : {1'b0, CFG_DMAC_BCR_IN[CNT_W-1:0]};
    assign s_word  = CFG_DMAC_MADR_IN[31:2] - 30'(n_words - RW'(1));

    // In SETUP the counters are still loading, so size the first burst from the config directly.
    assign calc_addr = (state == ST_SETUP) ? s_word  : addr_q;
    assign calc_rem  = (state == ST_SETUP) ? n_words : rem_q;

    dmac_burst_len_calc #(
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) u_len (
        .addr_lo   (calc_addr[OFS_W-1:0]),
        .remaining (calc_rem),
        .len       (len_c)
    );

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            state                    <= ST_IDLE;
            mode_q                   <= MODE_OT;
            addr_q                   <= '0;
            rem_q                    <= '0;
            fill_q                   <= '0;
            abort_q                  <= 1'b0;
            CFG_DMAC_CHCR_TR_CLR_OUT <= 1'b0;
            DONE_IRQ_OUT             <= 1'b0;
            BUSY_OUT                 <= 1'b0;
            BUS_START_ADDR_OUT       <= '0;
            BUS_WRITE_REQ_OUT        <= 1'b0;
            BUS_LEN_OUT              <= '0;
            BUS_WRITE_DATA_OUT       <= '0;
        end else if (EN) begin
            CFG_DMAC_CHCR_TR_CLR_OUT <= 1'b0;
            DONE_IRQ_OUT             <= 1'b0;
            case (state)
                ST_IDLE: begin
                    abort_q <= 1'b0;
                    if (CFG_DMAC_CHCR_TR_IN) begin
                        state    <= ST_SETUP;
                        BUSY_OUT <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    addr_q             <= s_word;
                    rem_q              <= n_words;
                    mode_q             <= dmac_mode_e'(CFG_MODE_IN);
                    fill_q             <= CFG_FILL_DATA_IN;
                    abort_q            <= CFG_ABORT_IN;
                    BUS_WRITE_DATA_OUT <= CFG_MODE_IN ? CFG_FILL_DATA_IN : OT_END;
                    BUS_LEN_OUT        <= len_c;
                    BUS_START_ADDR_OUT <= {s_word, 2'b00};
                    BUS_WRITE_REQ_OUT  <= 1'b1;
                    state              <= ST_REQ;
                end
                ST_REQ: begin
                    if (CFG_ABORT_IN)
                        abort_q <= 1'b1;
                    // Only the first beat is the terminator, so later beats link to addr_q.
                    if (BUS_WRITE_ACK_IN) begin
                        addr_q             <= addr_q + 30'd1;
                        rem_q              <= rem_q - RW'(1);
                        BUS_WRITE_DATA_OUT <= (mode_q == MODE_FILL) ? fill_q : ot_link_word(addr_q);
                    end
                    if (BUS_LAST_ACK_IN) begin
                        BUS_WRITE_REQ_OUT <= 1'b0;
                        state             <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (rem_q != '0 && !abort_q) begin
                        BUS_LEN_OUT        <= len_c;
                        BUS_START_ADDR_OUT <= {addr_q, 2'b00};
                        BUS_WRITE_REQ_OUT  <= 1'b1;
                        state              <= ST_REQ;
                    end else begin
                        CFG_DMAC_CHCR_TR_CLR_OUT <= 1'b1;
                        DONE_IRQ_OUT             <= !abort_q;
                        state                    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    BUSY_OUT <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmac_ot_fill.sv
// Randomised bench for dmac_ot_fill: a queue-based model of every burst and
// beat is compared against the bus port while a random slave stalls.
module tb_dmac_ot_fill;
    import psx_dmac_pkg::*;

    localparam int          BL  = 16;
    localparam int          CW  = 8;
    localparam logic [31:0] OTE = 32'h00FF_FFFF;

    logic        CLK = 1'b0;
    logic        RST_ASYNC, EN;
    logic [31:0] MADR, BCR, FILL;
    logic        MODE, TR, ABORT;
    logic        TR_CLR, IRQ, BUSY;
    logic [31:0] START;
    logic        RREQ, WREQ, WACK, LACK, RACK;
    logic [31:0] RDATA;
    logic [1:0]  SIZE;
    logic [4:0]  LEN;
    logic        INC;
    logic [31:0] DATA;

    always #5 CLK = ~CLK;

    dmac_ot_fill #(.BURST_LEN(BL), .CNT_W(CW), .OT_END(OTE)) dut (
        .CLK(CLK), .RST_ASYNC(RST_ASYNC), .EN(EN),
        .CFG_DMAC_MADR_IN(MADR), .CFG_DMAC_BCR_IN(BCR), .CFG_MODE_IN(MODE),
        .CFG_FILL_DATA_IN(FILL), .CFG_DMAC_CHCR_TR_IN(TR), .CFG_ABORT_IN(ABORT),
        .CFG_DMAC_CHCR_TR_CLR_OUT(TR_CLR), .DONE_IRQ_OUT(IRQ), .BUSY_OUT(BUSY),
        .BUS_START_ADDR_OUT(START), .BUS_READ_REQ_OUT(RREQ), .BUS_WRITE_REQ_OUT(WREQ),
        .BUS_WRITE_ACK_IN(WACK), .BUS_LAST_ACK_IN(LACK), .BUS_READ_ACK_IN(RACK),
        .BUS_READ_DATA_IN(RDATA), .BUS_SIZE_OUT(SIZE), .BUS_LEN_OUT(LEN),
        .BUS_BURST_ADDR_INC_OUT(INC), .BUS_WRITE_DATA_OUT(DATA)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [31:0] addr; logic [31:0] data; } beat_t;
    typedef struct { logic [31:0] addr; int len; } burst_t;
    beat_t  exp_beats[$];
    burst_t exp_bursts[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Words run upward from the lowest entry; each entry after the first holds
    // the byte address of the entry below it, the first holds the terminator.
    task automatic build_model(input logic [31:0] madr, input logic [31:0] bcr,
                               input logic mode, input logic [31:0] fill);
        int n, r, l;
        logic [29:0] s, a;
        exp_beats.delete();
        exp_bursts.delete();
        n = int'(bcr[CW-1:0]);
        if (n == 0) n = 1 << CW;
        s = madr[31:2] - 30'(n - 1);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            logic [29:0] w;
            logic [31:0] prev_byte;
            w         = s + 30'(i);
            prev_byte = {w - 30'd1, 2'b00};
            b.addr    = {w, 2'b00};
            b.data    = mode ? fill : ((i == 0) ? OTE : {8'h00, prev_byte[23:0]});
            exp_beats.push_back(b);
        end
        a = s;
        r = n;
        while (r > 0) begin
            burst_t bu;
            l = BL - (int'(a) % BL);
            if (r < l) l = r;
            bu.addr = {a, 2'b00};
            bu.len  = l;
            exp_bursts.push_back(bu);
            a = a + 30'(l);
            r = r - l;
        end
    endtask

    task automatic run_job(input logic [31:0] madr, input logic [31:0] bcr, input logic mode,
                           input logic [31:0] fill, input int abort_burst,
                           input int stall_pct, input int en_pct);
        int burst_idx, beat, cyc, irq_cnt, tr_cnt;
        logic prev_req, gap_due, done;
        burst_t cur;
        beat_t  eb;
        build_model(madr, bcr, mode, fill);
        if (abort_burst >= 0) begin
            int keep = 0;
            for (int k = 0; k <= abort_burst; k++) keep += exp_bursts[k].len;
            while (exp_bursts.size() > abort_burst + 1) void'(exp_bursts.pop_back());
            while (exp_beats.size() > keep) void'(exp_beats.pop_back());
        end
        cur = exp_bursts[0];
        @(negedge CLK);
        MADR = madr; BCR = bcr; MODE = mode; FILL = fill; TR = 1'b1; EN = 1'b1;
        @(posedge CLK); @(negedge CLK);
        chk("setup_busy", BUSY, 1);
        chk("setup_noreq", WREQ, 0);
        @(posedge CLK); @(negedge CLK);
        chk("tr_to_req_latency", WREQ, 1);
        prev_req = 1'b0; burst_idx = -1; beat = 0; cyc = 0;
        irq_cnt = 0; tr_cnt = 0; gap_due = 1'b0; done = 1'b0;
        while (!done && cyc < 4000) begin
            cyc++;
            if (gap_due) begin
                chk("gap_idle", WREQ, 0);
                gap_due = 1'b0;
            end
            if (IRQ) irq_cnt++;
            if (TR_CLR) begin
                tr_cnt++;
                chk("done_busy", BUSY, 1);
                TR = 1'b0; ABORT = 1'b0; EN = 1'b1; WACK = 1'b0; LACK = 1'b0;
                @(posedge CLK); @(negedge CLK);
                chk("idle_busy", BUSY, 0);
                @(posedge CLK); @(negedge CLK);
                chk("no_restart", BUSY, 0);
                done = 1'b1;
            end else begin
                WACK = 1'b0; LACK = 1'b0;
                if (WREQ && !prev_req) begin
                    burst_idx++;
                    beat = 0;
                    if (exp_bursts.size() == 0) chk("extra_burst", 1, 0);
                    else begin
                        cur = exp_bursts.pop_front();
                        chk("burst_addr", START, cur.addr);
                        chk("burst_len", 32'(LEN), cur.len);
                    end
                end else if (WREQ) begin
                    chk("addr_stable", START, cur.addr);
                    chk("len_stable", 32'(LEN), cur.len);
                end
                EN = (en_pct == 0) || ($urandom_range(0, 99) >= en_pct);
                if (WREQ && EN && $urandom_range(0, 99) >= stall_pct) begin
                    WACK = 1'b1;
                    if (exp_beats.size() == 0) chk("extra_beat", 1, 0);
                    else begin
                        eb = exp_beats.pop_front();
                        chk("beat_data", DATA, eb.data);
                        chk("beat_addr", START + 32'(4 * beat), eb.addr);
                    end
                    if (beat >= int'(LEN) - 1) LACK = 1'b1;
                end
                if (abort_burst >= 0 && burst_idx == abort_burst && beat == 1) ABORT = 1'b1;
                prev_req = WREQ;
                @(posedge CLK);
                if (WACK) beat++;
                if (LACK) gap_due = 1'b1;
                @(negedge CLK);
            end
        end
        if (!done) begin
            chk("job_timeout", 1, 0);
            TR = 1'b0; ABORT = 1'b0; WACK = 1'b0; LACK = 1'b0; EN = 1'b1;
            RST_ASYNC = 1'b1;
            @(negedge CLK);
            RST_ASYNC = 1'b0;
        end
        chk("trclr_pulses", tr_cnt, 1);
        chk("irq_pulses", irq_cnt, (abort_burst >= 0) ? 0 : 1);
        chk("beats_left", exp_beats.size(), 0);
        chk("bursts_left", exp_bursts.size(), 0);
    endtask

    initial begin
        RST_ASYNC = 1'b1; EN = 1'b1; MADR = '0; BCR = '0; FILL = '0; MODE = 1'b0;
        TR = 1'b0; ABORT = 1'b0; WACK = 1'b0; LACK = 1'b0; RACK = 1'b0; RDATA = '0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_wreq", WREQ, 0);
        chk("rst_rreq", RREQ, 0);
        chk("rst_trclr", TR_CLR, 0);
        chk("rst_irq", IRQ, 0);
        chk("rst_start", START, 0);
        chk("rst_len", 32'(LEN), 0);
        chk("rst_data", DATA, 0);
        chk("rst_size", 32'(SIZE), 2);
        chk("rst_inc", INC, 1);
        RST_ASYNC = 1'b0;

        build_model(32'h0001_00FC, 32'd4, 1'b0, 32'h0);
        chk("pin_t1_addr", exp_bursts[0].addr, 32'h0001_00F0);
        chk("pin_t1_len", exp_bursts[0].len, 4);
        chk("pin_t1_d0", exp_beats[0].data, 32'h00FF_FFFF);
        chk("pin_t1_d1", exp_beats[1].data, 32'h0001_00F0);
        chk("pin_t1_d3", exp_beats[3].data, 32'h0001_00F8);
        build_model(32'h0000_104C, 32'd20, 1'b0, 32'h0);
        chk("pin_t2_b0", exp_bursts[0].addr, 32'h0000_1000);
        chk("pin_t2_b1", exp_bursts[1].addr, 32'h0000_1040);
        chk("pin_t2_l1", exp_bursts[1].len, 4);
        chk("pin_t2_last", exp_beats[19].data, 32'h0000_1048);
        build_model(32'h0000_0004, 32'd3, 1'b0, 32'h0);
        chk("pin_wrap_a0", exp_bursts[0].addr, 32'hFFFF_FFFC);
        chk("pin_wrap_l0", exp_bursts[0].len, 1);
        chk("pin_wrap_d1", exp_beats[1].data, 32'h00FF_FFFC);
        build_model(32'h0000_0200, 32'd5, 1'b1, 32'hDEAD_BEEF);
        chk("pin_fill_a0", exp_bursts[0].addr, 32'h0000_01F0);
        chk("pin_fill_l0", exp_bursts[0].len, 4);
        chk("pin_fill_a1", exp_bursts[1].addr, 32'h0000_0200);

        run_job(32'h0001_00FC, 32'd4, 1'b0, 32'h0, -1, 0, 0);
        run_job(32'h0000_104C, 32'd20, 1'b0, 32'h0, -1, 0, 0);
        run_job(32'h0000_0004, 32'd3, 1'b0, 32'h0, -1, 25, 0);

        // An abort seen only while idle must not affect the next run.
        @(negedge CLK); ABORT = 1'b1;
        repeat (2) @(negedge CLK); ABORT = 1'b0;
        run_job(32'h0000_0200, 32'd5, 1'b1, 32'hDEAD_BEEF, -1, 20, 0);

        run_job(32'h0002_03FC, 32'hFFFF_FF00, 1'b0, 32'h0, -1, 30, 10);
        run_job(32'h0000_109C, 32'd40, 1'b0, 32'h0, 0, 20, 0);

        for (int j = 0; j < 6; j++)
            run_job($urandom, 32'($urandom_range(1, 60)), 1'($urandom_range(0, 1)),
                    $urandom, -1, 25, 8);

        // Asynchronous reset mid-burst drops the request without waiting for a clock.
        @(negedge CLK);
        MADR = 32'h0000_104C; BCR = 32'd20; MODE = 1'b0; TR = 1'b1; EN = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_mid_req_up", WREQ, 1);
        WACK = 1'b1;
        @(posedge CLK); @(negedge CLK);
        WACK = 1'b0; TR = 1'b0;
        RST_ASYNC = 1'b1;
        #1;
        chk("rst_mid_wreq", WREQ, 0);
        chk("rst_mid_busy", BUSY, 0);
        chk("rst_mid_len", 32'(LEN), 0);
        @(negedge CLK);
        RST_ASYNC = 1'b0;
        run_job(32'h0001_00FC, 32'd4, 1'b0, 32'h0, -1, 10, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
